// File: rtl/lcd_text_pkg.sv
// Shared definitions for the LCD text stream sequencer.
//   - Font cell sizes for the two glyph sizes of lcd_show_char.
//   - Sequencer state encoding.
//   - ASCII control codes. These are interpreted only when the design is
//     built with LCD_TEXT_CTRL_EN defined.
//   - Coordinate clamp helper for externally loaded cursor positions.
package lcd_text_pkg;

  localparam logic [4:0] FONT_W_SMALL = 5'd6;
  localparam logic [4:0] FONT_W_LARGE = 5'd8;
  localparam logic [4:0] FONT_H_SMALL = 5'd12;
  localparam logic [4:0] FONT_H_LARGE = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ADVANCE   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // An off-screen coordinate is pulled back to the origin.
  function automatic logic [8:0] clamp_coord(input logic [8:0] v, input logic [9:0] limit);
    return ({1'b0, v} >= limit) ? 9'd0 : v;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with show-ahead read.
//   - head always presents the oldest entry; pop discards it.
//   - A push while full or a pop while empty is ignored.
//   - A push and a pop in the same cycle leave the level unchanged.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and data
//   pop               remove the head entry
//   head              oldest entry (undefined while empty)
//   level             occupancy, 0..DEPTH
//   full, empty       occupancy flags
module char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (level_r == LW'(DEPTH));
  assign empty   = (level_r == {LW{1'b0}});
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign head    = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_stream.sv
// Character-stream sequencer in front of lcd_show_char.
// ASCII bytes are buffered in a FIFO. Each byte is issued as one
// show_char_flag pulse at the current cursor. The sequencer then waits for
// show_char_done and advances the cursor, with row and screen wrap.
// Optional build macro: LCD_TEXT_CTRL_EN. When it is defined, LF, CR and BS
// move the cursor and are never drawn.
// Ports:
//   sys_clk, sys_rst_n              clock, asynchronous active-low reset
//   init_done                       panel ready; gates issuing
//   char_valid/char_data/char_ready push interface
//   cursor_set/cursor_x/cursor_y    cursor load, clamped to the screen
//   en_size                         0: 12x6 font, 1: 16x8 font
//   show_char_done                  glyph finished by lcd_show_char
//   show_char_flag/ascii_num/start_x/start_y  glyph request
//   busy, fifo_level                status
module lcd_text_stream
  import lcd_text_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SCREEN_W   = 128,
  parameter int SCREEN_H   = 160
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_done,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       cursor_set,
  input  logic [8:0] cursor_x,
  input  logic [8:0] cursor_y,
  input  logic       en_size,
  input  logic       show_char_done,
  output logic       show_char_flag,
  output logic [7:0] ascii_num,
  output logic [8:0] start_x,
  output logic [8:0] start_y,
  output logic       busy,
  output logic [4:0] fifo_level
);
  localparam int         LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] SCR_W = 10'(SCREEN_W);
  localparam logic [9:0] SCR_H = 10'(SCREEN_H);

  state_t        state_r;
  logic [8:0]    cur_x_r;
  logic [8:0]    cur_y_r;
  logic [4:0]    w_r;
  logic [4:0]    h_r;
  logic          init_d_r;
  logic          skip_adv_r;

  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [7:0]    head_s;
  logic [LW-1:0] level_s;
  logic          init_rise_s;
  logic          start_s;
  logic          is_ctrl_s;
  logic          skip_set_s;
  logic [4:0]    cw_s;
  logic [4:0]    ch_s;
  logic [9:0]    x_sum_s;
  logic [9:0]    y_row_s;
  logic [9:0]    lf_y_s;
  logic [8:0]    adv_x_s;
  logic [8:0]    adv_y_s;
  logic [8:0]    lf_y_wrap_s;
  logic [8:0]    bs_x_s;
  logic [8:0]    eff_x_s;
  logic [8:0]    eff_y_s;

  assign pop_s = (state_r == ST_ISSUE);

  char_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (char_valid),
    .push_data (char_data),
    .pop       (pop_s),
    .head      (head_s),
    .level     (level_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign char_ready = ~full_s;
  assign fifo_level = 5'(level_s);
  assign busy       = (state_r != ST_IDLE) || (level_s != {LW{1'b0}});

  assign init_rise_s = init_done & ~init_d_r;
  assign start_s     = (state_r == ST_IDLE) && init_done && !empty_s;
  // The cursor returns to the origin on the init_done rising edge. A glyph
  // issued in that same cycle must therefore already use the origin.
  assign eff_x_s     = init_rise_s ? 9'd0 : cur_x_r;
  assign eff_y_s     = init_rise_s ? 9'd0 : cur_y_r;
  // A cursor load made while a glyph is pending replaces that glyph's
  // advance, so the load positions the next glyph exactly.
  assign skip_set_s  = (cursor_set && (start_s || state_r == ST_ISSUE || state_r == ST_WAIT_DONE))
                    || (init_rise_s && (state_r == ST_ISSUE || state_r == ST_WAIT_DONE));

`ifdef LCD_TEXT_CTRL_EN
  assign is_ctrl_s = (head_s == ASCII_LF) || (head_s == ASCII_CR) || (head_s == ASCII_BS);
`else
  assign is_ctrl_s = 1'b0;
`endif

  // Cursor after a drawn glyph: step right, wrap to next row, wrap to top.
  always_comb begin
    x_sum_s = {1'b0, cur_x_r} + {5'd0, w_r};
    if ((x_sum_s + {5'd0, w_r}) > SCR_W) begin
      adv_x_s = 9'd0;
      y_row_s = {1'b0, cur_y_r} + {5'd0, h_r};
    end else begin
      adv_x_s = x_sum_s[8:0];
      y_row_s = {1'b0, cur_y_r};
    end
    if ((y_row_s + {5'd0, h_r}) > SCR_H) begin
      adv_y_s = 9'd0;
    end else begin
      adv_y_s = y_row_s[8:0];
    end
  end

  // Live font size plus cursor targets for line feed and backspace.
  always_comb begin
    cw_s   = en_size ? FONT_W_LARGE : FONT_W_SMALL;
    ch_s   = en_size ? FONT_H_LARGE : FONT_H_SMALL;
    lf_y_s = {1'b0, cur_y_r} + {5'd0, ch_s};
    if ((lf_y_s + {5'd0, ch_s}) > SCR_H) begin
      lf_y_wrap_s = 9'd0;
    end else begin
      lf_y_wrap_s = lf_y_s[8:0];
    end
    if ({1'b0, cur_x_r} >= {5'd0, cw_s}) begin
      bs_x_s = cur_x_r - {4'd0, cw_s};
    end else begin
      bs_x_s = 9'd0;
    end
  end

  // Sequencer FSM, cursor and glyph request outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r        <= ST_IDLE;
      cur_x_r        <= 9'd0;
      cur_y_r        <= 9'd0;
      w_r            <= FONT_W_SMALL;
      h_r            <= FONT_H_SMALL;
      init_d_r       <= 1'b0;
      skip_adv_r     <= 1'b0;
      show_char_flag <= 1'b0;
      ascii_num      <= 8'd0;
      start_x        <= 9'd0;
      start_y        <= 9'd0;
    end else begin
      init_d_r       <= init_done;
      show_char_flag <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          skip_adv_r <= 1'b0;
          if (start_s) begin
            state_r <= ST_ISSUE;
            if (!is_ctrl_s) begin
              show_char_flag <= 1'b1;
              ascii_num      <= head_s;
              start_x        <= eff_x_s;
              start_y        <= eff_y_s;
            end
          end
        end
        ST_ISSUE: begin
          w_r <= cw_s;
          h_r <= ch_s;
          if (is_ctrl_s) begin
            state_r <= ST_IDLE;
            case (head_s)
              ASCII_LF: begin
                cur_x_r <= 9'd0;
                cur_y_r <= lf_y_wrap_s;
              end
              ASCII_CR: cur_x_r <= 9'd0;
              ASCII_BS: cur_x_r <= bs_x_s;
              default:  cur_x_r <= cur_x_r;
            endcase
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (show_char_done) begin
            state_r <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (!skip_adv_r) begin
            cur_x_r <= adv_x_s;
            cur_y_r <= adv_y_s;
          end
          skip_adv_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
      // Later assignments win: explicit load beats reinit, reinit beats advance.
      if (init_rise_s) begin
        cur_x_r <= 9'd0;
        cur_y_r <= 9'd0;
      end
      if (cursor_set) begin
        cur_x_r <= clamp_coord(cursor_x, SCR_W);
        cur_y_r <= clamp_coord(cursor_y, SCR_H);
      end
      if (skip_set_s) begin
        skip_adv_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_stream.sv
module tb_lcd_text_stream;
  localparam int SW = 128;
  localparam int SH = 160;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'd0;
  logic       cursor_set = 1'b0;
  logic [8:0] cursor_x = 9'd0;
  logic [8:0] cursor_y = 9'd0;
  logic       en_size = 1'b0;
  logic       show_char_done = 1'b0;
  wire        char_ready;
  wire        show_char_flag;
  wire  [7:0] ascii_num;
  wire  [8:0] start_x;
  wire  [8:0] start_y;
  wire        busy;
  wire  [4:0] fifo_level;

  lcd_text_stream dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .cursor_set(cursor_set), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .en_size(en_size), .show_char_done(show_char_done),
    .show_char_flag(show_char_flag), .ascii_num(ascii_num),
    .start_x(start_x), .start_y(start_y), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passes = 0;

  // Drawn glyphs seen on the bus and glyphs the model predicts: {ascii, x, y}.
  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];

  // Responder for lcd_show_char. It records each flag, watches the request for
  // stability while the glyph is pending, and returns done after done_lat cycles.
  int          done_lat = 5;
  int          lat_cnt = 0;
  bit          pend = 1'b0;
  int          hold_err = 0;
  logic [25:0] held = 26'd0;
  always @(negedge sys_clk) begin
    show_char_done = 1'b0;
    if (!sys_rst_n) begin
      pend = 1'b0;
    end else if (show_char_flag) begin
      held = {ascii_num, start_x, start_y};
      obs_q.push_back(held);
      pend = 1'b1;
      lat_cnt = done_lat;
    end else if (pend) begin
      if ({ascii_num, start_x, start_y} !== held) hold_err++;
      if (lat_cnt <= 1) begin
        show_char_done = 1'b1;
        pend = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
  end

  // Text cursor model in plain screen arithmetic.
  int mx = 0;
  int my = 0;

  task automatic model_set(input int x, input int y);
    mx = (x >= SW) ? 0 : x;
    my = (y >= SH) ? 0 : y;
  endtask

  task automatic model_char(input logic [7:0] c, input bit big, input bit no_advance);
    int w;
    int h;
    w = big ? 8 : 6;
    h = big ? 16 : 12;
`ifdef LCD_TEXT_CTRL_EN
    if (c == 8'h0A) begin
      mx = 0;
      my = my + h;
      if (my + h > SH) my = 0;
      return;
    end
    if (c == 8'h0D) begin
      mx = 0;
      return;
    end
    if (c == 8'h08) begin
      mx = (mx - w < 0) ? 0 : mx - w;
      return;
    end
`endif
    exp_q.push_back({c, 9'(mx), 9'(my)});
    if (!no_advance) begin
      mx = mx + w;
      if (mx + w > SW) begin
        mx = 0;
        my = my + h;
      end
      if (my + h > SH) my = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_char(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
  endtask

  task automatic set_cursor(input int x, input int y);
    cursor_set = 1'b1;
    cursor_x   = 9'(x);
    cursor_y   = 9'(y);
    tick();
    cursor_set = 1'b0;
    model_set(x, y);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 3000 && obs_q.size() < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) tick();
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_phase(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check($sformatf("%s_glyph%0d", tag, i), {6'd0, obs_q[i]}, {6'd0, exp_q[i]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_glyph();
    return 8'($urandom_range(32'h20, 32'h7E));
  endfunction

  initial begin
    logic [7:0] burst[16];
    logic [7:0] c;
    bit big;
    int n;

    // Reset state
    init_done = 1'b1;
    repeat (3) tick();
    check("rst_flag", {31'd0, show_char_flag}, 32'd0);
    check("rst_ready", {31'd0, char_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_ascii", {24'd0, ascii_num}, 32'd0);
    check("rst_xy", {14'd0, start_x, start_y}, 32'd0);
    sys_rst_n = 1'b1;
    model_set(0, 0);
    tick();

    // "AB" in the small font, done after 5 cycles
    done_lat = 5;
    en_size = 1'b0;
    push_char(8'h41); model_char(8'h41, 1'b0, 1'b0);
    push_char(8'h42); model_char(8'h42, 1'b0, 1'b0);
    check("ab_busy", {31'd0, busy}, 32'd1);
    wait_obs(2);
    wait_idle("ab");
    compare_phase("ab");

    // Large font at the right edge wraps to the next row
    en_size = 1'b1;
    set_cursor(120, 0);
    push_char(8'h43); model_char(8'h43, 1'b1, 1'b0);
    push_char(8'h44); model_char(8'h44, 1'b1, 1'b0);
    wait_obs(2);
    wait_idle("rowwrap");
    compare_phase("rowwrap");

    // Bottom-right corner wraps to the top
    set_cursor(120, 144);
    for (int i = 0; i < 2; i++) begin
      c = rand_glyph();
      push_char(c); model_char(c, 1'b1, 1'b0);
    end
    wait_obs(2);
    wait_idle("topwrap");
    compare_phase("topwrap");

    // Cursor load while a glyph is pending only affects the next glyph
    en_size = 1'b0;
    done_lat = 8;
    set_cursor(0, 0);
    c = rand_glyph();
    push_char(c); model_char(c, 1'b0, 1'b1);
    wait_obs(1);
    tick(); tick();
    set_cursor(30, 40);
    check("setwait_x", {23'd0, start_x}, 32'd0);
    check("setwait_y", {23'd0, start_y}, 32'd0);
    c = rand_glyph();
    push_char(c); model_char(c, 1'b0, 1'b0);
    wait_obs(2);
    wait_idle("setwait");
    compare_phase("setwait");

    // LF between two glyphs
    done_lat = 3;
    set_cursor(0, 0);
    push_char(8'h41); model_char(8'h41, 1'b0, 1'b0);
    push_char(8'h0A); model_char(8'h0A, 1'b0, 1'b0);
    push_char(8'h42); model_char(8'h42, 1'b0, 1'b0);
    wait_obs(exp_q.size());
    wait_idle("ctrl");
    compare_phase("ctrl");

    // Fill the FIFO with issuing disabled; the 17th push is dropped
    set_cursor(50, 60);
    init_done = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      c = rand_glyph();
      if (i < 16) burst[i] = c;
      push_char(c);
      if (i == 14) check("fill_ready15", {31'd0, char_ready}, 32'd1);
      if (i == 15) check("fill_ready16", {31'd0, char_ready}, 32'd0);
    end
    check("fill_level", {27'd0, fifo_level}, 32'd16);
    check("fill_ready", {31'd0, char_ready}, 32'd0);
    repeat (5) tick();
    check("fill_noflag", obs_q.size(), 32'd0);
    done_lat = $urandom_range(1, 4);
    init_done = 1'b1;
    model_set(0, 0);
    for (int i = 0; i < 16; i++) model_char(burst[i], 1'b0, 1'b0);
    wait_obs(16);
    wait_idle("fill");
    compare_phase("fill");

    // Reset with buffered characters discards them
    init_done = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push_char(rand_glyph());
    check("mid_level", {27'd0, fifo_level}, 32'd3);
    check("mid_busy", {31'd0, busy}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, char_ready}, 32'd1);
    tick();
    sys_rst_n = 1'b1;
    init_done = 1'b1;
    obs_q.delete();
    exp_q.delete();
    model_set(0, 0);
    tick();
    c = rand_glyph();
    push_char(c); model_char(c, 1'b0, 1'b0);
    wait_obs(1);
    wait_idle("postrst");
    compare_phase("postrst");

    // Random strings from random (possibly off-screen) cursor positions
    for (int it = 0; it < 6; it++) begin
      big = 1'($urandom_range(0, 1));
      en_size = big;
      done_lat = $urandom_range(1, 6);
      set_cursor($urandom_range(0, 140), $urandom_range(0, 170));
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        c = rand_glyph();
        push_char(c); model_char(c, big, 1'b0);
      end
      wait_obs(n);
      wait_idle($sformatf("rnd%0d", it));
      compare_phase($sformatf("rnd%0d", it));
    end

    check("hold_stable", hold_err, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
